// File: rtl/flappy_pkg.sv
// flappy_pkg: constants and types shared by the bird game-logic stage and
// the frame renderer.
//   - game_state_t      : IDLE/PLAYING/DYING/DEAD encoding (matches oState)
//   - fixed-point widths: position unsigned 10.4, velocity signed 11-bit
//   - screen and physics constants (pixels, 1/16 px/frame, frames)
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      DYING   = 2'd2,
      DEAD    = 2'd3
   } game_state_t;

   localparam int POS_FRAC       = 4;
   localparam int POS_INT_W      = 10;
   localparam int POS_W          = POS_INT_W + POS_FRAC;
   localparam int VEL_W          = 11;
   localparam int SCORE_W        = 16;
   localparam int RCNT_W         = 6;

   localparam int SCREEN_HEIGHT  = 480;
   localparam int BIRD_HEIGHT    = 24;
   localparam int START_Y        = 228;
   localparam int FLOOR_Y        = 400;
   localparam int GRAVITY        = 6;
   localparam int FLAP_IMPULSE   = 96;
   localparam int MAX_FALL       = 160;
   localparam int RESTART_FRAMES = 60;
   localparam int SCORE_MAX      = 999;

   localparam logic [POS_W-1:0] START_POS = POS_W'(START_Y << POS_FRAC);
   // Lowest allowed top edge: bird bottom sits exactly on the ground line.
   localparam logic [POS_W-1:0] FLOOR_POS = POS_W'((FLOOR_Y - BIRD_HEIGHT) << POS_FRAC);
   localparam logic [VEL_W-1:0] VEL_FLAP  = VEL_W'(-FLAP_IMPULSE);
   localparam logic [VEL_W-1:0] VEL_MAX   = VEL_W'(MAX_FALL);

   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/frame_event_latch.sv
// frame_event_latch: rising-edge detect plus a pending bit per channel.
// A pending bit is set by a rising edge and cleared by tick; event_now is
// what the tick in this cycle should act on, so an edge landing in the
// tick cycle is consumed by that tick and several edges in one frame
// collapse into one event.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tick       : frame tick, consumes pending events
//   level[N]   : input levels (button level or one-cycle pulses)
//   event_now[N]: pending-or-rising, valid in the tick cycle
module frame_event_latch #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic [N-1:0] level,
   output logic [N-1:0] event_now
);

   logic [N-1:0] prev;
   logic [N-1:0] pending;
   logic [N-1:0] rise;

   assign rise      = level & ~prev;
   assign event_now = pending | rise;

   always_ff @(posedge clk) begin
      // prev tracks the level through reset so a button held across
      // reset does not appear as a fresh edge.
      prev <= level;
      if (rst)
         pending <= '0;
      else if (tick)
         pending <= '0;
      else
         pending <= pending | rise;
   end

endmodule

// File: rtl/bird_physics_controller.sv
// bird_physics_controller: game state machine, bird vertical physics and
// score counter. Everything advances only on iFrameTick; outputs are
// registered and hold for the whole frame.
// Ports:
//   iClock, iReset : clock, synchronous active-high reset
//   iFrameTick     : one-cycle pulse at start of frame
//   iFlap          : flap button level (synchronised)
//   iPipePassed    : pulse when a pipe is cleared
//   iHit           : pulse on pipe collision
//   oBirdY[10]     : bird top-edge Y, integer pixels
//   oScore[16]     : score, saturates at 999
//   oState[2]      : IDLE=0 PLAYING=1 DYING=2 DEAD=3
//   oGameOver      : high in DEAD
// Optional feature macro BIRD_IDLE_BOB_EN: in IDLE the bird bobs in a
// +/-4 px triangle around START_Y, one pixel every 4 ticks.
module bird_physics_controller (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iFrameTick,
   input  logic        iFlap,
   input  logic        iPipePassed,
   input  logic        iHit,
   output logic [9:0]  oBirdY,
   output logic [15:0] oScore,
   output logic [1:0]  oState,
   output logic        oGameOver
);
   import flappy_pkg::*;

   logic [2:0] ev;
   logic       flap, pass, hit;

   frame_event_latch #(.N(3)) u_events (
      .clk       (iClock),
      .rst       (iReset),
      .tick      (iFrameTick),
      .level     ({iHit, iPipePassed, iFlap}),
      .event_now (ev)
   );
   assign flap = ev[0];
   assign pass = ev[1];
   assign hit  = ev[2];

   game_state_t                state, state_n;
   logic [POS_W-1:0]           pos, pos_n;
   logic [VEL_W-1:0]           vel, vel_n, vel_new, vel_fall;
   logic [VEL_W:0]             vel_g;
   logic [POS_W+1:0]           sum;
   logic [SCORE_W-1:0]         score, score_n;
   logic [RCNT_W-1:0]          rcnt, rcnt_n;
   logic [POS_INT_W-1:0]       y, y_n;
   logic                       integrate;

`ifdef BIRD_IDLE_BOB_EN
   logic [4:0] phase, phase_n;
   logic       bob_dir, bob_dir_n;
   logic [2:0] bob_step;
   logic [3:0] bob_off;
`endif

   // Gravity with terminal-velocity clamp; vel stays within [-96,160] so a
   // one-bit extension is enough to avoid wrap.
   assign vel_g    = {vel[VEL_W-1], vel} + (VEL_W+1)'(GRAVITY);
   assign vel_fall = (!vel_g[VEL_W] && (vel_g[VEL_W-1:0] > VEL_MAX)) ? VEL_MAX : vel_g[VEL_W-1:0];

   always_comb begin
      state_n   = state;
      pos_n     = pos;
      vel_n     = vel;
      score_n   = score;
      rcnt_n    = rcnt;
      integrate = 1'b0;
      vel_new   = vel_fall;
      sum       = '0;

      if (iFrameTick) begin
         unique case (state)
            IDLE: begin
               pos_n = START_POS;
               vel_n = '0;
               if (flap) begin
                  integrate = 1'b1;
                  vel_new   = VEL_FLAP;
                  state_n   = PLAYING;
               end
            end
            PLAYING: begin
               integrate = 1'b1;
               vel_new   = flap ? VEL_FLAP : vel_fall;
               if (pass) score_n = score_inc(score);
               if (hit)  state_n = DYING;
            end
            DYING: begin
               integrate = 1'b1;
               vel_new   = vel_fall;
            end
            DEAD: begin
               if (rcnt == RCNT_W'(RESTART_FRAMES)) begin
                  if (flap) begin
                     state_n = IDLE;
                     score_n = '0;
                     pos_n   = START_POS;
                     vel_n   = '0;
                     rcnt_n  = '0;
                  end
               end else begin
                  rcnt_n = rcnt + RCNT_W'(1);
               end
            end
            default: state_n = IDLE;
         endcase

         if (integrate) begin
            sum = {2'b00, pos} + {{(POS_W+2-VEL_W){vel_new[VEL_W-1]}}, vel_new};
            if (sum[POS_W+1]) begin
               // Above the ceiling: pin to the top and kill the upward motion.
               pos_n = '0;
               vel_n = '0;
            end else if (sum >= (POS_W+2)'(FLOOR_POS)) begin
               // Floor wins over a same-frame hit.
               pos_n   = FLOOR_POS;
               vel_n   = '0;
               state_n = DEAD;
            end else begin
               pos_n = sum[POS_W-1:0];
               vel_n = vel_new;
            end
         end
      end

      y_n = pos_n[POS_W-1:POS_FRAC];
`ifdef BIRD_IDLE_BOB_EN
      phase_n   = phase;
      bob_dir_n = bob_dir;
      if (state_n != IDLE) begin
         phase_n   = '0;
         bob_dir_n = 1'b0;
      end else if (iFrameTick) begin
         phase_n = phase + 5'd1;
         if (phase == 5'd31) bob_dir_n = ~bob_dir;
      end
      // 0,1,2,3,4,3,2,1 over one phase wrap; direction flips each wrap.
      bob_step = phase_n[4:2];
      bob_off  = bob_step[2] ? (4'd8 - {1'b0, bob_step}) : {1'b0, bob_step};
      if (state_n == IDLE)
         y_n = bob_dir_n ? POS_INT_W'(START_Y) - POS_INT_W'(bob_off)
                         : POS_INT_W'(START_Y) + POS_INT_W'(bob_off);
`endif
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state <= IDLE;
         pos   <= START_POS;
         vel   <= '0;
         score <= '0;
         rcnt  <= '0;
         y     <= POS_INT_W'(START_Y);
`ifdef BIRD_IDLE_BOB_EN
         phase   <= '0;
         bob_dir <= 1'b0;
`endif
      end else begin
         state <= state_n;
         pos   <= pos_n;
         vel   <= vel_n;
         score <= score_n;
         rcnt  <= rcnt_n;
         y     <= y_n;
`ifdef BIRD_IDLE_BOB_EN
         phase   <= phase_n;
         bob_dir <= bob_dir_n;
`endif
      end
   end

   assign oBirdY    = y;
   assign oScore    = score;
   assign oState    = state;
   assign oGameOver = (state == DEAD);

endmodule
